// File: rtl/ife_pkg.sv
// Shared types and default sizes for the IFE dual-execution path.
// Used by ife_block_dispatcher, ife_result_snapshot and ife_commit_unit.
package ife_pkg;

  localparam int DEF_BLOCK_ID_WIDTH = 8;
  localparam int DEF_NUM_REGS       = 32;
  localparam int DEF_REG_WIDTH      = 32;
  localparam int DEF_PC_WIDTH       = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PAR,
    ST_COMPARE,
    ST_SER_LAUNCH,
    ST_WAIT_SER,
    ST_RETIRE
  } dispatch_state_e;

  typedef logic [DEF_NUM_REGS-1:0][DEF_REG_WIDTH-1:0] reg_file_t;

endpackage

// File: rtl/ife_result_snapshot.sv
// Capture-on-done register file for one core's result.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   clear               - empty the snapshot and drop the done flag
//   capture             - core done pulse, already qualified by the caller
//   ignore_after_first  - when high, a capture after the flag is set is dropped
//   regs_in             - core result registers, valid with capture
//   regs                - held snapshot
//   done_flag           - a result has been captured since the last clear
module ife_result_snapshot
  import ife_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                capture,
  input  logic                                ignore_after_first,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs_in,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs,
  output logic                                done_flag
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      regs      <= '0;
      done_flag <= 1'b0;
    end else if (capture && !(ignore_after_first && done_flag)) begin
      regs      <= regs_in;
      done_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ife_block_dispatcher.sv
// Front end of the IFE dual-execution path. Launches one block on both
// cores, snapshots both results for ife_commit_unit, and on a mismatch or
// parallel timeout re-runs the block serially on core 0. Exactly one
// retirement per accepted block, in acceptance order.
// Ports:
//   blk_valid/blk_ready/blk_id/blk_pc       - block offer handshake
//   coreN_start/coreN_pc/core0_serial       - core launch controls
//   coreN_done/coreN_regs                   - core completion and results
//   cmp_valid/cmp_block_id/cmp_result_N     - to commit unit
//   commit_ok/commit_fail                   - commit unit verdict
//   retire_valid/retire_block_id/retire_regs/retire_serial - retirement
//   timeout                                 - parallel wait expired pulse
//
// state         | meaning
// IDLE          | ready for a block
// WAIT_PAR      | both cores running, collecting done pulses
// COMPARE       | snapshots presented to commit unit for one cycle
// SER_LAUNCH    | core 0 relaunched for serial re-execution
// WAIT_SER      | waiting for the serial core 0 result
// RETIRE        | retirement pulse
module ife_block_dispatcher
  import ife_pkg::*;
#(
  parameter int BLOCK_ID_WIDTH = DEF_BLOCK_ID_WIDTH,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int REG_WIDTH      = DEF_REG_WIDTH,
  parameter int PC_WIDTH       = DEF_PC_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                blk_valid,
  output logic                                blk_ready,
  input  logic [BLOCK_ID_WIDTH-1:0]           blk_id,
  input  logic [PC_WIDTH-1:0]                 blk_pc,
  output logic                                core0_start,
  output logic                                core1_start,
  output logic [PC_WIDTH-1:0]                 core0_pc,
  output logic [PC_WIDTH-1:0]                 core1_pc,
  output logic                                core0_serial,
  input  logic                                core0_done,
  input  logic                                core1_done,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  core0_regs,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  core1_regs,
  output logic                                cmp_valid,
  output logic [BLOCK_ID_WIDTH-1:0]           cmp_block_id,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  cmp_result_0,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  cmp_result_1,
  input  logic                                commit_ok,
  input  logic                                commit_fail,
  output logic                                retire_valid,
  output logic [BLOCK_ID_WIDTH-1:0]           retire_block_id,
  output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  retire_regs,
  output logic                                retire_serial,
  output logic                                timeout
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dispatch_state_e                     state;
  logic [BLOCK_ID_WIDTH-1:0]           id_q;
  logic [PC_WIDTH-1:0]                 pc_q;
  logic [CNT_W-1:0]                    wait_cnt;
  logic                                snap_clear;
  logic                                snap0_capture;
  logic                                snap0_ignore;
  logic                                snap1_capture;
  logic                                flag0;
  logic                                flag1;
  logic                                both_done;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  snap0_regs;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  snap1_regs;

  // Snapshots are emptied on the accepting edge so WAIT_PAR starts clean.
  assign snap_clear    = (state == ST_IDLE) && blk_valid;
  // Core 0 keeps its first parallel result, but the serial result must
  // overwrite it even though the flag is already set.
  assign snap0_capture = core0_done && ((state == ST_WAIT_PAR) || (state == ST_WAIT_SER));
  assign snap0_ignore  = (state == ST_WAIT_PAR);
  assign snap1_capture = core1_done && (state == ST_WAIT_PAR);
  // Include this cycle's pulses so a same-cycle pair moves on immediately.
  assign both_done     = (flag0 || core0_done) && (flag1 || core1_done);

  ife_result_snapshot #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) u_snap0 (
    .clk                (clk),
    .rst                (rst),
    .clear              (snap_clear),
    .capture            (snap0_capture),
    .ignore_after_first (snap0_ignore),
    .regs_in            (core0_regs),
    .regs               (snap0_regs),
    .done_flag          (flag0)
  );

  ife_result_snapshot #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) u_snap1 (
    .clk                (clk),
    .rst                (rst),
    .clear              (snap_clear),
    .capture            (snap1_capture),
    .ignore_after_first (1'b1),
    .regs_in            (core1_regs),
    .regs               (snap1_regs),
    .done_flag          (flag1)
  );

  assign core0_pc     = pc_q;
  assign core1_pc     = pc_q;
  assign cmp_block_id = id_q;
  assign cmp_result_0 = snap0_regs;
  assign cmp_result_1 = snap1_regs;
  assign retire_regs  = retire_valid ? snap0_regs : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      blk_ready       <= 1'b1;
      id_q            <= '0;
      pc_q            <= '0;
      wait_cnt        <= '0;
      core0_start     <= 1'b0;
      core1_start     <= 1'b0;
      core0_serial    <= 1'b0;
      cmp_valid       <= 1'b0;
      retire_valid    <= 1'b0;
      retire_block_id <= '0;
      retire_serial   <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      core0_start  <= 1'b0;
      core1_start  <= 1'b0;
      cmp_valid    <= 1'b0;
      retire_valid <= 1'b0;
      timeout      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            id_q        <= blk_id;
            pc_q        <= blk_pc;
            wait_cnt    <= '0;
            core0_start <= 1'b1;
            core1_start <= 1'b1;
            blk_ready   <= 1'b0;
            state       <= ST_WAIT_PAR;
          end
        end
        ST_WAIT_PAR: begin
          if (both_done) begin
            cmp_valid <= 1'b1;
            state     <= ST_COMPARE;
          end else if (wait_cnt == CNT_LAST) begin
            timeout      <= 1'b1;
            core0_start  <= 1'b1;
            core0_serial <= 1'b1;
            state        <= ST_SER_LAUNCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_COMPARE: begin
          // A silent commit unit is treated as a failed comparison.
          if (commit_ok && !commit_fail) begin
            retire_valid    <= 1'b1;
            retire_block_id <= id_q;
            retire_serial   <= 1'b0;
            state           <= ST_RETIRE;
          end else begin
            core0_start  <= 1'b1;
            core0_serial <= 1'b1;
            state        <= ST_SER_LAUNCH;
          end
        end
        ST_SER_LAUNCH: begin
          state <= ST_WAIT_SER;
        end
        ST_WAIT_SER: begin
          if (core0_done) begin
            core0_serial    <= 1'b0;
            retire_valid    <= 1'b1;
            retire_block_id <= id_q;
            retire_serial   <= 1'b1;
            state           <= ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          retire_block_id <= '0;
          retire_serial   <= 1'b0;
          blk_ready       <= 1'b1;
          state           <= ST_IDLE;
        end
        default: begin
          blk_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ife_block_dispatcher.sv
module tb_ife_block_dispatcher;
  import ife_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [7:0]  blk_id = '0;
  logic [31:0] blk_pc = '0;
  logic        core0_start, core1_start, core0_serial;
  logic [31:0] core0_pc, core1_pc;
  logic        core0_done = 1'b0, core1_done = 1'b0;
  reg_file_t   core0_regs = '0, core1_regs = '0;
  logic        cmp_valid;
  logic [7:0]  cmp_block_id;
  reg_file_t   cmp_result_0, cmp_result_1;
  logic        commit_ok, commit_fail;
  logic        retire_valid, retire_serial, timeout;
  logic [7:0]  retire_block_id;
  reg_file_t   retire_regs;

  always #5 clk = ~clk;

  // Commit unit model: equality verdict, combinational from cmp_*.
  assign commit_ok   = cmp_valid && (cmp_result_0 == cmp_result_1);
  assign commit_fail = cmp_valid && (cmp_result_0 != cmp_result_1);

  ife_block_dispatcher #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_id(blk_id), .blk_pc(blk_pc),
    .core0_start(core0_start), .core1_start(core1_start),
    .core0_pc(core0_pc), .core1_pc(core1_pc), .core0_serial(core0_serial),
    .core0_done(core0_done), .core1_done(core1_done),
    .core0_regs(core0_regs), .core1_regs(core1_regs),
    .cmp_valid(cmp_valid), .cmp_block_id(cmp_block_id),
    .cmp_result_0(cmp_result_0), .cmp_result_1(cmp_result_1),
    .commit_ok(commit_ok), .commit_fail(commit_fail),
    .retire_valid(retire_valid), .retire_block_id(retire_block_id),
    .retire_regs(retire_regs), .retire_serial(retire_serial), .timeout(timeout)
  );

  typedef struct {
    logic [7:0] id;
    reg_file_t  regs;
    logic       serial;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input reg_file_t obs, input reg_file_t exp);
    int bad;
    bad = 0;
    for (int i = DEF_NUM_REGS - 1; i >= 0; i--)
      if (obs[i] !== exp[i]) bad = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s reg[%0d] observed=%h expected=%h", tag, bad, obs[bad], exp[bad]);
    end
  endtask

  function automatic reg_file_t fill(input logic [31:0] w);
    reg_file_t r;
    for (int i = 0; i < DEF_NUM_REGS; i++) r[i] = w;
    return r;
  endfunction

  function automatic reg_file_t pat(input logic [31:0] base);
    reg_file_t r;
    for (int i = 0; i < DEF_NUM_REGS; i++) r[i] = base + 32'(i);
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] id, input reg_file_t regs, input logic serial);
    exp_t e;
    e.id = id; e.regs = regs; e.serial = serial;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Accept a block; returns at the negedge where the start pulses are visible.
  task automatic offer(input logic [7:0] id, input logic [31:0] pc);
    blk_valid = 1'b1; blk_id = id; blk_pc = pc;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (core1_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, core1_start, 1'b1);
  endtask

  // Retirement scoreboard.
  always @(negedge clk) begin
    if (retire_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected", retire_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("retire_id", retire_block_id, mon_e.id);
        chk("retire_serial", retire_serial, mon_e.serial);
        chk_regs("retire_regs", retire_regs, mon_e.regs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_file_t r_a, r_b, r_c;
    int t_seen;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_ctrl", {core0_start, core1_start, core0_serial, cmp_valid,
                     retire_valid, retire_serial, timeout, blk_ready}, 8'b0000_0001);
    chk("rst_pc", {core0_pc, core1_pc}, 64'd0);
    chk("rst_ids", {cmp_block_id, retire_block_id}, 16'd0);
    chk_regs("rst_cmp0", cmp_result_0, '0);
    chk_regs("rst_cmp1", cmp_result_1, '0);
    chk_regs("rst_retire", retire_regs, '0);

    // Matching results, both done in the same cycle
    offer(8'h12, 32'h0000_1000);
    chk("m_start", {core0_start, core1_start, core0_serial}, 3'b110);
    chk("m_pc", {core0_pc, core1_pc}, {32'h0000_1000, 32'h0000_1000});
    chk("m_ready_low", blk_ready, 1'b0);
    tick();
    r_a = fill(32'hA5A5_A5A5);
    core0_done = 1'b1; core1_done = 1'b1; core0_regs = r_a; core1_regs = r_a;
    push_exp(8'h12, r_a, 1'b0);
    tick();
    core0_done = 1'b0; core1_done = 1'b0;
    chk("m_cmp_valid", cmp_valid, 1'b1);
    chk("m_cmp_id", cmp_block_id, 8'h12);
    chk_regs("m_cmp_r0", cmp_result_0, r_a);
    chk_regs("m_cmp_r1", cmp_result_1, r_a);
    tick();
    chk("m_cmp_one_cycle", cmp_valid, 1'b0);
    chk("m_retire_at_d2", retire_valid, 1'b1);
    tick();
    chk("m_ready_at_d3", {blk_ready, retire_valid}, 2'b10);

    // Skewed done with a register mismatch, serial re-run
    offer(8'h34, 32'h0000_2000);
    tick();
    r_a = pat(32'h0100_0000);
    r_b = r_a; r_b[5] = 32'hFFFF_0005;
    core0_done = 1'b1; core0_regs = r_a;
    tick();
    core0_done = 1'b0;
    repeat (6) tick();
    core1_done = 1'b1; core1_regs = r_b;
    tick();
    core1_done = 1'b0;
    chk("s_cmp_valid", cmp_valid, 1'b1);
    chk_regs("s_cmp_r1", cmp_result_1, r_b);
    tick();
    chk("s_ser_start", {core0_start, core1_start, core0_serial}, 3'b101);
    chk("s_ser_pc", core0_pc, 32'h0000_2000);
    tick(); tick();
    chk("s_serial_held", core0_serial, 1'b1);
    r_c = r_a; r_c[5] = 32'h0000_0055;
    core0_done = 1'b1; core0_regs = r_c;
    push_exp(8'h34, r_c, 1'b1);
    tick();
    core0_done = 1'b0;
    chk("s_retire_at_s1", retire_valid, 1'b1);
    tick();
    chk("s_ready", {blk_ready, core0_serial}, 2'b10);

    // Timeout: core 1 never finishes in time
    offer(8'h56, 32'h0000_3000);
    t_seen = -1;
    r_a = fill(32'h1111_2222);
    r_b = fill(32'hBAD0_BAD0);
    r_c = pat(32'h3300_0000);
    for (int k = 0; k <= 27; k++) begin
      if (timeout === 1'b1 && t_seen < 0) t_seen = k;
      if (k == 16) chk("t_ser_start", {core0_start, core1_start, core0_serial}, 3'b101);
      if (k == 17) chk("t_pulse_one_cycle", timeout, 1'b0);
      if (k == 21) chk("t_retire", retire_valid, 1'b1);
      if (k == 22) chk("t_ready", blk_ready, 1'b1);
      if (k > 22) chk("t_no_late_retire", retire_valid, 1'b0);
      core0_done = 1'b0; core1_done = 1'b0;
      case (k)
        3:  begin core0_done = 1'b1; core0_regs = r_a; end
        16: begin core0_done = 1'b1; core0_regs = r_b; end
        18: begin core1_done = 1'b1; core1_regs = r_b; end
        20: begin core0_done = 1'b1; core0_regs = r_c; push_exp(8'h56, r_c, 1'b1); end
        23: begin core0_done = 1'b1; core1_done = 1'b1; end
        default: ;
      endcase
      tick();
    end
    core0_done = 1'b0; core1_done = 1'b0;
    chk("t_timeout_cycle", 64'(t_seen), 64'd16);

    // Back-pressure: blk_valid held high across three blocks
    blk_valid = 1'b1; blk_id = 8'h61; blk_pc = 32'h0000_4000;
    for (int b = 0; b < 3; b++) begin
      wait_start($sformatf("bp_start%0d", b));
      chk($sformatf("bp_id%0d", b), cmp_block_id, 8'h61 + 8'(b));
      blk_id = 8'h62 + 8'(b);
      for (int c = 0; c < 2; c++) begin
        tick();
        chk("bp_wait", {core0_start, core1_start, blk_ready}, 3'b000);
      end
      r_a = pat(32'h0000_1000 * b);
      core0_done = 1'b1; core1_done = 1'b1; core0_regs = r_a; core1_regs = r_a;
      push_exp(8'h61 + 8'(b), r_a, 1'b0);
      tick();
      core0_done = 1'b0; core1_done = 1'b0;
      chk("bp_cmp", {cmp_valid, core1_start}, 2'b10);
      tick();
      chk("bp_retire", {retire_valid, core1_start}, 2'b10);
      tick();
    end
    blk_valid = 1'b0;
    chk("bp_ready", blk_ready, 1'b1);

    // Reset in the middle of WAIT_PAR
    offer(8'h77, 32'h0000_5000);
    tick();
    core0_done = 1'b1; core0_regs = fill(32'hDEAD_BEEF);
    tick();
    core0_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_ctrl", {core0_start, core1_start, core0_serial, cmp_valid,
                   retire_valid, retire_serial, timeout, blk_ready}, 8'b0000_0001);
    chk("r_pc_ids", {core0_pc, cmp_block_id, retire_block_id}, 48'd0);
    chk_regs("r_snap0", cmp_result_0, '0);
    core0_done = 1'b1; core1_done = 1'b1;
    tick();
    core0_done = 1'b0; core1_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("r_stale_quiet", {retire_valid, core0_start, cmp_valid, blk_ready}, 4'b0001);
      tick();
    end

    // Duplicate core 0 done before core 1
    offer(8'h88, 32'h0000_6000);
    r_a = pat(32'h0000_0100);
    r_b = pat(32'h0000_0900);
    core0_done = 1'b1; core0_regs = r_a;
    tick();
    core0_regs = r_b;
    tick();
    core0_done = 1'b0;
    core1_done = 1'b1; core1_regs = r_a;
    push_exp(8'h88, r_a, 1'b0);
    tick();
    core1_done = 1'b0;
    chk("d_cmp_valid", cmp_valid, 1'b1);
    chk_regs("d_first_snapshot", cmp_result_0, r_a);
    tick();
    chk("d_retire", {retire_valid, retire_serial}, 2'b10);
    repeat (3) tick();

    chk("sb_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
